// File: rtl/ifetch_unit_pkg.sv
// rtl/ifetch_unit_pkg.sv - shared constants and FSM encoding for the instruction fetch unit
package ifetch_unit_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [31:0] NOP        = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] next_word(input logic [31:0] addr);
        return addr + 32'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/ifetch_buf.sv
// rtl/ifetch_buf.sv - single-entry {instr, pc} prefetch holding register
module ifetch_buf
    import ifetch_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_instr,
    input  logic [31:0] load_pc,
    output logic        full,
    output logic [31:0] instr,
    output logic [31:0] pc
);
    logic        full_q, full_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;

    always_comb begin
        full_d  = full_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear) begin
            full_d = 1'b0;
        end else if (load) begin
            full_d  = 1'b1;
            instr_d = load_instr;
            pc_d    = load_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            full_q  <= 1'b0;
            instr_q <= NOP;
            pc_q    <= '0;
        end else begin
            full_q  <= full_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign full  = full_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - fetch front end: owns the PC, imem req/ack, redirect and wrong-path squash
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        do_branch,
    input  logic [31:0] branch_addr,
    input  logic        do_jump,
    input  logic [31:0] jump_addr
);
    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  redir_pc_q, redir_pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_q, pc_d;
    logic         valid_q, valid_d;
    logic         squash_q, squash_d;

    logic         accept, redirect, req_ack, resp_take, to_output;
    logic [31:0]  target;
    logic         buf_load, buf_clear, buf_full;
    logic [31:0]  buf_instr, buf_pc;

    assign accept    = valid_q & instr_ready;
    assign redirect  = accept & (do_jump | do_branch);
    assign target    = (do_jump ? jump_addr : branch_addr) & ~32'd3;
    assign req_ack   = (state_q == ST_REQ) & imem_ack;
    assign resp_take = req_ack & ~squash_q & ~redirect;
    assign to_output = ~valid_q | accept;

    ifetch_buf u_buf (
        .clock      (clock),
        .reset      (reset),
        .load       (buf_load),
        .clear      (buf_clear),
        .load_instr (imem_rdata),
        .load_pc    (fetch_pc_q),
        .full       (buf_full),
        .instr      (buf_instr),
        .pc         (buf_pc)
    );

    always_ff @(posedge clock) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // A response that cannot reach the output parks in the buffer and stops fetching.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ:  if (resp_take && !to_output) state_d = ST_HOLD;
            ST_HOLD: if (accept) state_d = ST_REQ;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req    = (state_q == ST_REQ);
        imem_addr   = fetch_pc_q;
        instruction = instr_q;
        pc          = pc_q;
        pc4         = next_word(pc_q);
        instr_valid = valid_q;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        redir_pc_d = redir_pc_q;
        squash_d   = squash_q;
        valid_d    = valid_q & ~accept;
        instr_d    = instr_q;
        pc_d       = pc_q;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;
        if (redirect) begin
            buf_clear = 1'b1;
            // An unacked request must stay on the bus; remember the target until it drains.
            if (state_q == ST_REQ && !imem_ack) begin
                squash_d   = 1'b1;
                redir_pc_d = target;
            end else begin
                fetch_pc_d = target;
            end
        end else begin
            if (req_ack && squash_q) begin
                squash_d   = 1'b0;
                fetch_pc_d = redir_pc_q;
            end
            if (accept && buf_full) begin
                valid_d   = 1'b1;
                instr_d   = buf_instr;
                pc_d      = buf_pc;
                buf_clear = 1'b1;
            end
            if (resp_take) begin
                fetch_pc_d = next_word(fetch_pc_q);
                if (to_output) begin
                    valid_d = 1'b1;
                    instr_d = imem_rdata;
                    pc_d    = fetch_pc_q;
                end else begin
                    buf_load = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            redir_pc_q <= RESET_PC;
            squash_q   <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= NOP;
            pc_q       <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            redir_pc_q <= redir_pc_d;
            squash_q   <= squash_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - scoreboard bench for ifetch_unit against a program-order reference model
module tb_ifetch_unit;

    localparam logic [31:0] RESET_A = 32'h0000_0000;
    localparam logic [31:0] RESET_B = 32'hFFFF_FFF8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        imem_req, imem_ack, instr_valid, instr_ready, do_branch, do_jump;
    logic [31:0] imem_addr, imem_rdata, instruction, pc, pc4, branch_addr, jump_addr;
    logic        imem_req_b, instr_valid_b;
    logic [31:0] imem_addr_b, rdata_b, instruction_b, pc_b, pc4_b;

    int checks = 0;
    int errors = 0;
    int lat_mode, ready_mode, br_mode;
    int wait_left, n_accept;
    bit wait_armed;
    logic [31:0] model_pc;
    logic [31:0] exp_q[$];
    logic [31:0] ack_log[$];
    logic [31:0] b_addrs[$];
    logic [31:0] b_pcs[$];
    logic [31:0] b_pc4s[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign rdata_b = mem_word(imem_addr_b);

    ifetch_unit #(.RESET_PC(RESET_A)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instruction(instruction), .pc(pc), .pc4(pc4), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .do_branch(do_branch), .branch_addr(branch_addr), .do_jump(do_jump), .jump_addr(jump_addr)
    );

    ifetch_unit #(.RESET_PC(RESET_B)) dut_wrap (
        .clock(clock), .reset(reset),
        .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_ack(imem_req_b), .imem_rdata(rdata_b),
        .instruction(instruction_b), .pc(pc_b), .pc4(pc4_b), .instr_valid(instr_valid_b), .instr_ready(1'b1),
        .do_branch(1'b0), .branch_addr(32'h0), .do_jump(1'b0), .jump_addr(32'h0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic int lat_for(input logic [31:0] a);
        case (lat_mode)
            1:       return (a == 32'hC) ? 3 : 0;
            2:       return int'($urandom_range(0, 3));
            3:       return 2;
            default: return 0;
        endcase
    endfunction

    task automatic reset_model();
        exp_q.delete();
        exp_q.push_back(RESET_A);
        model_pc   = RESET_A;
        ack_log.delete();
        wait_armed = 1'b0;
        n_accept   = 0;
    endtask

    task automatic drive_mem();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        if (imem_req) begin
            if (!wait_armed) begin
                wait_armed = 1'b1;
                wait_left  = lat_for(imem_addr);
            end
            if (wait_left == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                wait_armed = 1'b0;
            end else begin
                wait_left--;
            end
        end else begin
            wait_armed = 1'b0;
        end
    endtask

    // Reference: program order is pc+4 unless the consumed instruction redirects (jump wins).
    task automatic drive_consumer();
        logic [31:0] nxt;
        case (ready_mode)
            0:       instr_ready = 1'b1;
            1:       instr_ready = 1'b0;
            default: instr_ready = ($urandom_range(0, 9) < 7);
        endcase
        do_branch   = 1'b0;
        do_jump     = 1'b0;
        branch_addr = $urandom;
        jump_addr   = $urandom;
        case (br_mode)
            1: if (model_pc == 32'h8) begin
                do_branch = 1'b1; branch_addr = 32'h40;
            end
            2: if (model_pc == 32'h4) begin
                do_jump = 1'b1; jump_addr = 32'h0040_0000;
                do_branch = 1'b1; branch_addr = 32'h80;
            end
            3: begin
                do_branch   = ($urandom_range(0, 4) == 0);
                do_jump     = ($urandom_range(0, 6) == 0);
                branch_addr = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom)};
                jump_addr   = {12'h004, 18'($urandom_range(0, 1023)), 2'($urandom)};
            end
            default: ;
        endcase
        if (reset && instr_valid && instr_ready) begin
            if (do_jump)        nxt = jump_addr & 32'hFFFF_FFFC;
            else if (do_branch) nxt = branch_addr & 32'hFFFF_FFFC;
            else                nxt = model_pc + 32'd4;
            exp_q.push_back(nxt);
            model_pc = nxt;
            n_accept++;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        drive_mem();
        drive_consumer();
    endtask

    task automatic do_reset(input bit check_state);
        @(posedge clock);
        #1;
        reset = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0; do_branch = 1'b0; do_jump = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        if (check_state) begin
            chk("rst_valid", {31'd0, instr_valid}, 32'd0);
            chk("rst_req", {31'd0, imem_req}, 32'd0);
            chk("rst_pc", pc, RESET_A);
            chk("rst_pc4", pc4, RESET_A + 32'd4);
            chk("rst_instr", instruction, 32'd0);
            chk("rst_pc_wrap", pc_b, RESET_B);
            chk("rst_pc4_wrap", pc4_b, RESET_B + 32'd4);
        end
        reset = 1'b1;
        reset_model();
    endtask

    // Scoreboard monitor and bus-protocol checks.
    logic [31:0] prev_addr;
    bit prev_pending = 1'b0;
    always @(negedge clock) begin
        logic [31:0] exp_pc;
        if (!reset) begin
            prev_pending = 1'b0;
        end else begin
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_empty actual=%08h required=<none>", pc);
                end else begin
                    exp_pc = exp_q.pop_front();
                    chk("pc", pc, exp_pc);
                    chk("pc4", pc4, exp_pc + 32'd4);
                    chk("instr", instruction, mem_word(exp_pc));
                end
            end
            if (prev_pending) begin
                chk("req_held", {31'd0, imem_req}, 32'd1);
                chk("addr_stable", imem_addr, prev_addr);
            end
            if (imem_req) begin
                chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
                if (imem_ack) ack_log.push_back(imem_addr);
            end
            prev_pending = imem_req && !imem_ack;
            prev_addr    = imem_addr;
            if (imem_req_b && b_addrs.size() < 3) b_addrs.push_back(imem_addr_b);
            if (instr_valid_b && b_pcs.size() < 3) begin
                b_pcs.push_back(pc_b);
                b_pc4s.push_back(pc4_b);
                chk("wrap_instr", instruction_b, mem_word(pc_b));
            end
        end
    end

    initial begin
        imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0; do_branch = 1'b0; do_jump = 1'b0;
        branch_addr = '0; jump_addr = '0;
        lat_mode = 0; ready_mode = 0; br_mode = 0; n_accept = 0; model_pc = RESET_A;

        // Streaming with same-cycle acks
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) begin
            step();
            if (i >= 1) chk("valid_steady", {31'd0, instr_valid}, 32'd1);
        end
        chk("seq_addr0", q_at(ack_log, 0), 32'h0);
        chk("seq_addr1", q_at(ack_log, 1), 32'h4);
        chk("seq_addr2", q_at(ack_log, 2), 32'h8);
        chk("seq_addr3", q_at(ack_log, 3), 32'hC);
        chk("wrap_addr0", q_at(b_addrs, 0), 32'hFFFF_FFF8);
        chk("wrap_addr1", q_at(b_addrs, 1), 32'hFFFF_FFFC);
        chk("wrap_addr2", q_at(b_addrs, 2), 32'h0000_0000);
        chk("wrap_pc1", q_at(b_pcs, 1), 32'hFFFF_FFFC);
        chk("wrap_pc4_1", q_at(b_pc4s, 1), 32'h0000_0000);
        chk("wrap_pc2", q_at(b_pcs, 2), 32'h0000_0000);

        // Back-pressure: one prefetch then the bus goes quiet
        do_reset(1'b0);
        ready_mode = 1;
        repeat (6) step();
        chk("hold_req_count", ack_log.size(), 32'd2);
        chk("hold_req_addr", q_at(ack_log, 1), 32'h4);
        chk("hold_req_idle", {31'd0, imem_req}, 32'd0);
        ready_mode = 0;
        repeat (6) step();
        chk("hold_progress", 32'(n_accept >= 4), 32'd1);

        // Branch while the request to C is stalled
        do_reset(1'b0);
        lat_mode = 1; br_mode = 1;
        repeat (14) step();
        chk("squash_addr", q_at(ack_log, 3), 32'hC);
        chk("branch_addr", q_at(ack_log, 4), 32'h40);
        chk("branch_progress", 32'(n_accept >= 6), 32'd1);

        // Jump and branch on the same accept
        do_reset(1'b0);
        lat_mode = 0; br_mode = 2;
        repeat (10) step();
        chk("jump_addr", q_at(ack_log, 3), 32'h0040_0000);
        chk("jump_progress", 32'(n_accept >= 5), 32'd1);

        // Reset in the cycle an ack arrives
        do_reset(1'b0);
        lat_mode = 3; br_mode = 0; ready_mode = 1;
        repeat (6) step();
        for (int i = 0; i < 20 && !imem_ack; i++) step();
        chk("rst_ack_seen", {31'd0, imem_ack}, 32'd1);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
        chk("midrst_req", {31'd0, imem_req}, 32'd0);
        chk("midrst_pc", pc, RESET_A);
        chk("midrst_instr", instruction, 32'd0);
        reset = 1'b1; imem_ack = 1'b0;
        reset_model();
        step();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, RESET_A);

        // Randomized latency, back-pressure and redirects
        do_reset(1'b0);
        lat_mode = 2; ready_mode = 2; br_mode = 3;
        repeat (3000) step();
        chk("rand_progress", 32'(n_accept > 200), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch front end for the MIPS datapath; the producer side of the execute stage's pc4 / branch / jump interface.
- Owns the PC and issues word requests to instruction memory over a req/ack handshake.
- Presents {instruction, pc, pc4} to decode/execute with a valid/ready handshake.
- Consumes do_branch/branch_addr and do_jump/jump_addr from execute to redirect, squashing any wrong-path prefetch.

Parameters:
- RESET_PC, 32'h0000_0000, address of the first fetch after reset (bits [1:0] must be 00).

Ports:
- clock  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clock edge)
- imem_req  out  1  memory request valid; held with imem_addr stable until imem_ack
- imem_addr  out  32  word address of request; [1:0] always 00
- imem_ack  in  1  response valid; imem_rdata is meaningful this cycle; may assert in the same cycle as imem_req
- imem_rdata  in  32  instruction word
- instruction  out  32  current instruction to decode
- pc  out  32  address of the current instruction
- pc4  out  32  pc + 4, fed to execute
- instr_valid  out  1  instruction/pc/pc4 valid
- instr_ready  in  1  downstream consumes the current instruction this cycle
- do_branch  in  1  taken-branch flag for the instruction being consumed
- branch_addr  in  32  branch target
- do_jump  in  1  jump flag for the instruction being consumed
- jump_addr  in  32  jump target

Behaviour:
- Reset (reset==0 at an edge):
  - imem_req=0, instr_valid=0, instruction=0, pc=RESET_PC, pc4=RESET_PC+4.
  - Prefetch buffer empty, squash flag clear, FSM=IDLE, fetch_pc=RESET_PC.
  - Reset mid-request drops the transaction; an imem_ack arriving in the reset cycle is ignored.
- Accept = instr_valid & instr_ready. do_branch/do_jump are sampled only on accept and ignored otherwise.
- Redirect = accept & (do_jump | do_branch). Jump has priority when both are set. Target[1:0] is forced to 00.
- FSM states:
  - IDLE: one cycle after reset -> REQ.
  - REQ: imem_req=1, imem_addr=fetch_pc. On imem_ack -> RESP handling; stay in REQ otherwise.
  - HOLD: no request; output valid and prefetch buffer full. Leaves HOLD on accept.
- Response handling, when an ack arrives and the squash flag is clear:
  - Output empty, or output accepted this cycle with no redirect: the word goes to the output register. instr_valid=1 next cycle, pc=fetch_pc, pc4=fetch_pc+4.
  - Otherwise the word goes to the prefetch buffer with its address.
  - In both cases fetch_pc += 4.
- Request issue:
  - A new request starts the cycle after an ack only if the prefetch buffer will be empty.
  - This keeps at most one instruction in the output, one in the buffer and one in flight.
- Accept without redirect:
  - If the buffer is full, its contents move to the output next cycle and the buffer empties.
  - Otherwise, if the response is in the same cycle, that response moves to the output.
  - Otherwise instr_valid=0 next cycle.
- Redirect:
  - Next cycle: instr_valid=0, buffer cleared, fetch_pc=target.
  - If a request is outstanding and not acked this cycle, set the squash flag and keep imem_req/imem_addr held until ack. The squashed ack is discarded and clears the flag; the target request issues the following cycle.
  - If the outstanding request is acked in the redirect cycle, drop that data.
  - Otherwise issue REQ for the target next cycle.
- Minimum latency: ack to instr_valid is 1 cycle. Redirect accept to first target request is 1 cycle, or the cycle after the squashed ack.
- Address arithmetic is mod 2^32: fetch_pc=32'hFFFF_FFFC increments to 0.
- imem_req never drops before imem_ack. imem_addr is stable while imem_req=1 and no ack.

Decomposition:
- Shared package/include: FSM state encodings (IDLE, REQ, HOLD), the WORD_BYTES=4 constant, NOP=32'h0000_0000.
- One natural sub-module, ifetch_buf: a single-entry {instr, pc} holding register with load/clear/full.
- The FSM and redirect/squash logic stay in the top.

Test Plan:
- Reset, RESET_PC=0, memory acks in the same cycle, instr_ready=1 -> imem_addr sequence 0,4,8,C. Outputs pc=0,4,8 with pc4=4,8,C and instructions matching memory. instr_valid stays high after the first cycle.
- Hold instr_ready=0 for 5 cycles after the first valid -> exactly one further request (addr 4) goes out and then imem_req=0. On release, pc advances 0 -> 4 -> 8 with no lost or duplicated word.
- Accept pc=8 with do_branch=1, branch_addr=32'h40, and the memory ack delayed 3 cycles on an outstanding request to C -> the C data is discarded. The next imem_addr is 40; the next valid pc=40, pc4=44.
- do_jump=1, jump_addr=32'h0040_0000 together with do_branch=1, branch_addr=32'h80 on the same accept -> next fetch and pc are 32'h0040_0000.
- Assert reset=0 while imem_req=1 awaiting ack, with an ack arriving in the same cycle -> next cycle instr_valid=0 and pc=RESET_PC. The first request after IDLE is to RESET_PC.
- RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000. For pc=FFFF_FFFC the output pc4=0.
